// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signal bundle for mem_port_arbiter.
// The arbiter connects through the slave modport; the surrounding environment uses master.
interface mem_port_arbiter_if #(
    parameter int WORD_SIZE        = 32,
    parameter int BLOCK_DATA_WIDTH = 512
);
    logic                        req0_enable;
    logic                        req0_rw;
    logic [WORD_SIZE-1:0]        req0_addr;
    logic [BLOCK_DATA_WIDTH-1:0] req0_dataout;
    logic [BLOCK_DATA_WIDTH-1:0] req0_datain;
    logic                        req0_ready;

    logic                        req1_enable;
    logic                        req1_rw;
    logic [WORD_SIZE-1:0]        req1_addr;
    logic [BLOCK_DATA_WIDTH-1:0] req1_dataout;
    logic [BLOCK_DATA_WIDTH-1:0] req1_datain;
    logic                        req1_ready;

    logic                        res_error;
    logic                        grant_id;
    logic                        busy;

    logic                        mem_req_enable;
    logic                        mem_req_rw;
    logic [WORD_SIZE-1:0]        mem_req_addr;
    logic [BLOCK_DATA_WIDTH-1:0] mem_req_dataout;
    logic [BLOCK_DATA_WIDTH-1:0] mem_req_datain;
    logic                        mem_req_ready;

    modport slave (
        input  req0_enable, req0_rw, req0_addr, req0_dataout,
        input  req1_enable, req1_rw, req1_addr, req1_dataout,
        input  mem_req_datain, mem_req_ready,
        output req0_datain, req0_ready, req1_datain, req1_ready,
        output res_error, grant_id, busy,
        output mem_req_enable, mem_req_rw, mem_req_addr, mem_req_dataout
    );

    modport master (
        output req0_enable, req0_rw, req0_addr, req0_dataout,
        output req1_enable, req1_rw, req1_addr, req1_dataout,
        output mem_req_datain, mem_req_ready,
        input  req0_datain, req0_ready, req1_datain, req1_ready,
        input  res_error, grant_id, busy,
        input  mem_req_enable, mem_req_rw, mem_req_addr, mem_req_dataout
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter placing I-side and D-side cache block traffic onto one memory port,
// one transaction at a time, with a watchdog on the memory response.
module mem_port_arbiter #(
    parameter int WORD_SIZE        = 32,
    parameter int BLOCK_DATA_WIDTH = 512,
    parameter int OFFSET_BITS      = 6,
    parameter int TIMEOUT          = 64,
    parameter int TIMER_BITS       = 7
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                      state_reg, state_next;
    logic [TIMER_BITS-1:0]       timer_reg, timer_next;
    logic                        last_grant_reg, last_grant_next;
    logic                        grant_id_reg, grant_id_next;
    logic                        busy_reg, busy_next;
    logic                        mem_enable_reg, mem_enable_next;
    logic                        mem_rw_reg, mem_rw_next;
    logic [WORD_SIZE-1:0]        mem_addr_reg, mem_addr_next;
    logic [BLOCK_DATA_WIDTH-1:0] mem_data_reg, mem_data_next;
    logic                        res_error_reg, res_error_next;
    logic [1:0]                  ready_reg, ready_next;

    logic                        grant;
    logic                        capture;
    logic [BLOCK_DATA_WIDTH-1:0] capture_data;

    logic [1:0]                  req_enable;
    logic                        req_rw   [2];
    logic [WORD_SIZE-1:0]        req_addr [2];
    logic [BLOCK_DATA_WIDTH-1:0] req_data [2];

    assign req_enable  = {bus.req1_enable, bus.req0_enable};
    assign req_rw[0]   = bus.req0_rw;
    assign req_rw[1]   = bus.req1_rw;
    assign req_addr[0] = bus.req0_addr;
    assign req_addr[1] = bus.req1_addr;
    assign req_data[0] = bus.req0_dataout;
    assign req_data[1] = bus.req1_dataout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            timer_reg      <= '0;
            last_grant_reg <= 1'b1;
            grant_id_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            mem_enable_reg <= 1'b0;
            mem_rw_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_data_reg   <= '0;
            res_error_reg  <= 1'b0;
            ready_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            timer_reg      <= timer_next;
            last_grant_reg <= last_grant_next;
            grant_id_reg   <= grant_id_next;
            busy_reg       <= busy_next;
            mem_enable_reg <= mem_enable_next;
            mem_rw_reg     <= mem_rw_next;
            mem_addr_reg   <= mem_addr_next;
            mem_data_reg   <= mem_data_next;
            res_error_reg  <= res_error_next;
            ready_reg      <= ready_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        timer_next      = timer_reg;
        last_grant_next = last_grant_reg;
        grant_id_next   = grant_id_reg;
        busy_next       = busy_reg;
        mem_enable_next = mem_enable_reg;
        mem_rw_next     = mem_rw_reg;
        mem_addr_next   = mem_addr_reg;
        mem_data_next   = mem_data_reg;
        res_error_next  = res_error_reg;
        ready_next      = '0;
        grant           = 1'b0;
        capture         = 1'b0;
        capture_data    = '0;

        case (state_reg)
            IDLE: begin
                timer_next = '0;
                if (req_enable != 2'b00) begin
                    // A lone request wins outright; a tie goes to whoever was not served last.
                    grant           = (req_enable == 2'b11) ? ~last_grant_reg : req_enable[1];
                    grant_id_next   = grant;
                    last_grant_next = grant;
                    mem_rw_next     = req_rw[grant];
                    mem_addr_next   = {req_addr[grant][WORD_SIZE-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                    mem_data_next   = req_data[grant];
                    mem_enable_next = 1'b1;
                    busy_next       = 1'b1;
                    state_next      = MEM;
                end
            end
            MEM: begin
                // Ready is tested ahead of the watchdog so a last-cycle response is not an error.
                if (bus.mem_req_ready) begin
                    capture                  = 1'b1;
                    capture_data             = mem_rw_reg ? '0 : bus.mem_req_datain;
                    res_error_next           = 1'b0;
                    ready_next[grant_id_reg] = 1'b1;
                    mem_enable_next          = 1'b0;
                    state_next               = RESP;
                end else if (timer_reg == TIMER_BITS'(TIMEOUT - 1)) begin
                    capture                  = 1'b1;
                    capture_data             = '0;
                    res_error_next           = 1'b1;
                    ready_next[grant_id_reg] = 1'b1;
                    mem_enable_next          = 1'b0;
                    state_next               = RESP;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            RESP: begin
                res_error_next = 1'b0;
                busy_next      = 1'b0;
                timer_next     = '0;
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Each requester keeps its own returned block until its next completion.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_datain
            logic [BLOCK_DATA_WIDTH-1:0] datain_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    datain_reg <= '0;
                end else if (capture && (grant_id_reg == 1'(gi))) begin
                    datain_reg <= capture_data;
                end
            end
        end
    endgenerate

    assign bus.req0_datain     = g_datain[0].datain_reg;
    assign bus.req1_datain     = g_datain[1].datain_reg;
    assign bus.req0_ready      = ready_reg[0];
    assign bus.req1_ready      = ready_reg[1];
    assign bus.res_error       = res_error_reg;
    assign bus.grant_id        = grant_id_reg;
    assign bus.busy            = busy_reg;
    assign bus.mem_req_enable  = mem_enable_reg;
    assign bus.mem_req_rw      = mem_rw_reg;
    assign bus.mem_req_addr    = mem_addr_reg;
    assign bus.mem_req_dataout = mem_data_reg;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates two block-level requesters onto the single shared memory port. The requesters are the instruction-side and data-side cache controllers (refill/eviction traffic). The block is round-robin, runs one transaction at a time, and has a response-timeout watchdog. It sits between the cache controllers' mem_req_* interfaces and the memory model/controller.

Parameters:
WORD_SIZE, 32, address width in bits
BLOCK_DATA_WIDTH, 512, block transfer width (16 words)
OFFSET_BITS, 6, byte-offset bits cleared on outgoing address
TIMEOUT, 64, max cycles waiting for mem_req_ready (>=2)
TIMER_BITS, 7, width of watchdog counter (must hold TIMEOUT)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
req0_enable  in  1  requester 0 request, level, held until req0_ready
req0_rw  in  1  1=write block to memory, 0=read block
req0_addr  in  WORD_SIZE  byte address
req0_dataout  in  BLOCK_DATA_WIDTH  write block
req0_datain  out  BLOCK_DATA_WIDTH  read block returned
req0_ready  out  1  one-cycle completion pulse
req1_enable/req1_rw/req1_addr/req1_dataout/req1_datain/req1_ready  same as req0, requester 1
res_error  out  1  timeout flag, valid only with a reqN_ready pulse
grant_id  out  1  requester owning current transaction
busy  out  1  high from grant through response
mem_req_enable  out  1  memory request, level
mem_req_rw  out  1  latched rw
mem_req_addr  out  WORD_SIZE  latched addr, low OFFSET_BITS forced 0
mem_req_dataout  out  BLOCK_DATA_WIDTH  latched write block
mem_req_datain  in  BLOCK_DATA_WIDTH  read block from memory
mem_req_ready  in  1  memory completion, one cycle

Behaviour:
- All outputs are registered. Reset sets every output to 0, state=IDLE, timer=0 and last_grant=1, so req0 wins the first tie.
- States: IDLE, MEM, RESP.
- IDLE:
  - If exactly one reqN_enable is high, grant it.
  - If both are high, grant !last_grant.
  - On grant: latch rw/addr/dataout, set grant_id and last_grant, then go to MEM.
  - Next cycle: mem_req_enable=1 and busy=1. Grant-to-enable latency is 1 cycle.
- MEM:
  - Hold mem_req_enable and the latched fields stable, and increment the timer.
  - On mem_req_ready=1: capture mem_req_datain (reads only; writes return 0), go to RESP, and drop mem_req_enable on the next edge.
  - If the timer reaches TIMEOUT-1 without ready: go to RESP with res_error=1 and datain=0.
  - Ready and timeout in the same cycle: ready wins, no error.
- RESP:
  - Assert req{grant_id}_ready=1 for exactly one cycle, with datain/res_error valid. The other requester's ready stays 0.
  - Then go to IDLE, clearing busy and the timer.
- Requesters drop enable on the edge after they see ready, so IDLE never re-grants a completed request.
- Minimum transaction is 3 cycles (grant edge, MEM with immediate ready, RESP). Back-to-back grants to alternate requesters resume from IDLE.
- A requester dropping enable mid-transaction is ignored; the transaction completes and the ready pulse is still issued.
- mem_req_ready seen in IDLE or RESP is ignored.
- Requests are never preempted; only one transaction is outstanding.
- reqN_datain holds its last value until the next completion for that requester.
- Reset asserted mid-transaction aborts it with no ready pulse.

Test Plan:
- Single read: req0_enable, rw=0, addr=0x0000_0047; memory returns 512'hDEADBEEF<<480 three cycles after mem_req_enable -> mem_req_addr=0x0000_0040, req0_ready pulses 1 cycle with that data, res_error=0, grant_id=0.
- Tie: req0 and req1 both assert at once after reset -> req0 served first, then req1 (grant_id 0 then 1). Re-assert both -> req0 again (last_grant=1).
- Fairness: req1 continuously re-requests while req0 is pending -> grants alternate 0,1,0,1 and no requester is served twice in a row.
- Write: req1 rw=1, addr=0x100, dataout=512'hCAFEFACE… -> mem_req_rw=1, mem_req_dataout matches, req1_ready pulse, req1_datain=0.
- Timeout: mem_req_ready never asserted -> after 64 cycles in MEM, req0_ready=1 with res_error=1, and the arbiter returns to IDLE. The boundary case, ready in cycle 64, completes with res_error=0.
- Reset mid-MEM: assert rst for 1 cycle -> mem_req_enable=0, busy=0, no ready pulse. The next tie grants req0.
